// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction boot loader.
//   state_t      : loader session states
//   HDR_BYTES    : bytes per header word / per instruction word
//   BYTE_W       : bits per stream byte
//   LANE_FIRST/LANE_LAST : byte-lane indices within a 32-bit word
//   insert_byte  : place one byte into a word at a given lane (little-endian)
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam logic [1:0]  LANE_FIRST = 2'd0;
  localparam logic [1:0]  LANE_LAST  = 2'(HDR_BYTES - 1);

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[lane*BYTE_W +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Four-byte little-endian word assembler, shared by header and data phases.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart assembly at lane 0
//   i_byte         : incoming byte
//   i_accept       : i_byte is consumed this cycle
//   o_word         : word including the byte being accepted this cycle
//   o_last         : this cycle's accepted byte completes a word
module byte_assembler
  import instr_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_accept,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;
  logic [31:0] w_next;

  always_comb begin
    w_next = insert_byte(r_word, r_lane, i_byte);
  end

  assign o_word = w_next;
  assign o_last = i_accept && (r_lane == LANE_LAST);

  // Lane counter is 2 bits so it wraps 3 -> 0 on its own.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word <= '0;
      r_lane <= LANE_FIRST;
    end else if (i_accept) begin
      r_word <= w_next;
      r_lane <= r_lane + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-stream instruction loader: reads a 4-byte little-endian word count N,
// then N little-endian instruction words, and writes each to instruction
// memory while holding the core in reset.
//   clk, reset      : clock, synchronous active-high reset
//   start           : one-cycle pulse, begins a session (IDLE/DONE/ERR only)
//   in_byte/in_valid/in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data     : instruction memory write port
//   core_hold       : core held in reset (HDR, DATA, ERR)
//   done, error     : session completed / header count too large
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE) + 1;

  state_t                r_state;
  logic [31:0]           r_count;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic        w_accept;
  logic        w_start_ok;
  logic        w_last;
  logic [31:0] w_word;

  // The write cycle doubles as a one-cycle bubble on the byte stream.
  assign in_ready   = ((r_state == ST_HDR) || (r_state == ST_DATA)) && !r_wr_en;
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));

  byte_assembler u_asm (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (w_start_ok),
    .i_byte   (in_byte),
    .i_accept (w_accept),
    .o_word   (w_word),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state <= ST_HDR;
            r_count <= '0;
            r_idx   <= '0;
          end
        end
        ST_HDR: begin
          if (w_last) begin
            r_count <= w_word;
            if (w_word == '0)
              r_state <= ST_DONE;
            else if (w_word > 32'(MEM_SIZE))
              r_state <= ST_ERR;
            else
              r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_last) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_WIDTH'({r_idx, 2'b00});
            r_wr_data <= DATA_WIDTH'(w_word);
            r_idx     <= r_idx + 1'b1;
            // Leaving DATA on the same edge that raises wr_en makes done
            // visible together with the final write.
            if (32'(r_idx) == r_count - 32'd1)
              r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign core_hold = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_ERR);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERR);

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  instr_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_SIZE   (512)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
      check("in_ready_in_wr_cycle", 64'(in_ready), 64'd0);
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit jitter);
    int unsigned guard;
    guard = 0;
    if (jitter) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: got in_ready %0b, expected 1", in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit jitter);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w;
      send_byte(t[8*i +: 8], jitter);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {in_ready, wr_en, core_hold, done, error, wr_addr, wr_data},
          {5'b0, 32'h0, 32'h0});
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h);
    check(name, {61'b0, done, error, core_hold}, {61'b0, d, e, h});
  endtask

  task automatic check_drained(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};
    reset    = 1'b1;
    start    = 1'b0;
    in_byte  = '0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset_state");

    // Two-word load, byte-level vector
    push(32'h0, 32'h0000_0013);
    push(32'h4, 32'h0010_0093);
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(s1[i], 1'b0);
    repeat (2) @(negedge clk);
    check_status("two_word_status", 1'b1, 1'b0, 1'b0);
    check_drained("two_word_drained");

    // Zero-length header
    pulse_start();
    check_status("hdr_hold", 1'b0, 1'b0, 1'b1);
    send_word(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_status("zero_len_status", 1'b1, 1'b0, 1'b0);

    // Count 513 -> error
    pulse_start();
    send_word(32'h0000_0201, 1'b0);
    repeat (2) @(negedge clk);
    check_status("count513_status", 1'b0, 1'b1, 1'b1);
    check("count513_in_ready", 64'(in_ready), 64'd0);

    // Count 512 -> DATA (restart from ERR)
    pulse_start();
    send_word(32'h0000_0200, 1'b0);
    @(negedge clk);
    check_status("count512_status", 1'b0, 1'b0, 1'b1);
    check("count512_in_ready", 64'(in_ready), 64'd1);
    do_reset();
    check_idle_outputs("abort512_reset");

    // Three words with randomly gapped in_valid
    push(32'h0, 32'h1122_3344);
    push(32'h4, 32'hDEAD_BEEF);
    push(32'h8, 32'h0000_0001);
    pulse_start();
    send_word(32'd3, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    send_word(32'h0000_0001, 1'b1);
    repeat (2) @(negedge clk);
    check_status("gapped_status", 1'b1, 1'b0, 1'b0);
    check_drained("gapped_drained");

    // Reset mid-word, then reload from address 0
    push(32'h0, 32'hA5A5_0F0F);
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'hA5A5_0F0F, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    do_reset();
    check_idle_outputs("midword_reset");
    @(negedge clk);
    check("post_reset_wr_en", 64'(wr_en), 64'd0);
    check_drained("midword_drained");
    push(32'h0, 32'hCAFE_F00D);
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    repeat (2) @(negedge clk);
    check_status("reload_status", 1'b1, 1'b0, 1'b0);
    check_drained("reload_drained");

    // start during DATA is ignored
    push(32'h0, 32'h0403_0201);
    push(32'h4, 32'h0807_0605);
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(32'h0807_0605, 1'b0);
    repeat (2) @(negedge clk);
    check_status("start_ignored_status", 1'b1, 1'b0, 1'b0);
    check_drained("start_ignored_drained");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
